// File: rtl/hls_deadlock_report_ctrl_pkg.sv
// Shared types and helpers for the deadlock report sequencer.
// HLS_DL_RR_ARB_EN selects round-robin origin arbitration.
package hls_deadlock_report_ctrl_pkg;

   localparam int DL_MAX_PROC = 32;
   localparam int DL_MAX_ID_W = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ORIGIN = 2'd1,
      WALK   = 2'd2,
      REPORT = 2'd3
   } dl_state_e;

   typedef struct packed {
      logic [DL_MAX_ID_W-1:0] proc_id;
      logic [DL_MAX_PROC-1:0] chain;
      logic                   timeout;
   } dl_report_t;

   function automatic logic [DL_MAX_PROC-1:0] dl_onehot(input int idx);
      return DL_MAX_PROC'(1) << idx;
   endfunction

   function automatic int dl_clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/hls_deadlock_report_ctrl_arbiter.sv
// Combinational origin picker: first request at or after start_i, wrapping.
// Fixed lowest-index priority is the start_i == 0 case.
module hls_dl_proc_arbiter #(
   parameter int PROC_NUM = 4,
   parameter int ID_W     = 2
) (
   input  logic [PROC_NUM-1:0] req_i,
   input  logic [ID_W-1:0]     start_i,
   output logic [PROC_NUM-1:0] gnt_o,
   output logic [ID_W-1:0]     id_o
);

   logic            found;
   logic [ID_W-1:0] sel;

   always_comb begin
      gnt_o = '0;
      id_o  = '0;
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < PROC_NUM; k++) begin
         sel = ID_W'((int'(start_i) + k) % PROC_NUM);
         if (!found && req_i[sel]) begin
            found      = 1'b1;
            gnt_o[sel] = 1'b1;
            id_o       = sel;
         end
      end
   end

endmodule

// File: rtl/hls_deadlock_report_ctrl.sv
// Deadlock episode sequencer: pick origin, walk token, emit one report.
// Define HLS_DL_RR_ARB_EN for round-robin origin selection.
module hls_deadlock_report_ctrl
   import hls_deadlock_report_ctrl_pkg::*;
#(
   parameter int PROC_NUM      = 4,
   parameter int ID_W          = 2,
   parameter int TOKEN_TIMEOUT = 64
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [PROC_NUM-1:0] dl_detect_vec,
   input  logic [PROC_NUM-1:0] token_seen_vec,
   output logic                dl_detect_bcast,
   output logic [PROC_NUM-1:0] origin_vec,
   output logic [PROC_NUM-1:0] token_clear_vec,
   output logic                report_valid,
   input  logic                report_ready,
   output logic [ID_W-1:0]     report_proc_id,
   output logic [PROC_NUM-1:0] report_chain,
   output logic                report_timeout
);

   localparam int TW = dl_clog2(TOKEN_TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(TOKEN_TIMEOUT - 1);

   dl_state_e           state_q, state_d;
   dl_report_t          rep_q, rep_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [ID_W-1:0]     win, arb_id, arb_start;
   logic [PROC_NUM-1:0] arb_gnt, win_oh;
   logic                arb_any, ret, tmo;

   assign win     = ID_W'(rep_q.proc_id);
   assign win_oh  = PROC_NUM'(dl_onehot(int'(win)));
   assign arb_any = |arb_gnt;
   // The origin still holds its own token in the first WALK cycle.
   assign ret     = dl_detect_vec[win] & token_seen_vec[win]
                    & (timer_q != '0);
   assign tmo     = timer_q == T_LAST;

`ifdef HLS_DL_RR_ARB_EN
   logic [ID_W-1:0] rr_q, rr_d;
   logic            hs;

   assign hs        = (state_q == REPORT) & report_ready;
   assign arb_start = rr_q;

   always_comb begin
      rr_d = rr_q;
      if (hs) rr_d = ID_W'((int'(win) + 1) % PROC_NUM);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) rr_q <= '0;
      else       rr_q <= rr_d;
   end
`else
   assign arb_start = '0;
`endif

   hls_dl_proc_arbiter #(
      .PROC_NUM (PROC_NUM),
      .ID_W     (ID_W)
   ) u_arb (
      .req_i   (dl_detect_vec),
      .start_i (arb_start),
      .gnt_o   (arb_gnt),
      .id_o    (arb_id)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (arb_any) state_d = ORIGIN;
         ORIGIN:  state_d = WALK;
         WALK:    if (ret || tmo) state_d = REPORT;
         REPORT:  if (report_ready) state_d = IDLE;
      endcase
   end

   always_comb begin
      rep_d   = rep_q;
      timer_d = timer_q;
      unique case (state_q)
         IDLE: begin
            if (arb_any) begin
               rep_d.proc_id = DL_MAX_ID_W'(arb_id);
               rep_d.chain   = '0;
               rep_d.timeout = 1'b0;
            end
         end
         ORIGIN: begin
            rep_d.chain = DL_MAX_PROC'(win_oh);
            timer_d     = '0;
         end
         WALK: begin
            rep_d.chain = rep_q.chain | DL_MAX_PROC'(token_seen_vec);
            if (timer_q != '1) timer_d = timer_q + 1'b1;
            if (ret)      rep_d.timeout = 1'b0;
            else if (tmo) rep_d.timeout = 1'b1;
         end
         REPORT: begin
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rep_q   <= '0;
         timer_q <= '0;
      end else begin
         rep_q   <= rep_d;
         timer_q <= timer_d;
      end
   end

   always_comb begin
      dl_detect_bcast = 1'b0;
      origin_vec      = '0;
      token_clear_vec = '0;
      report_valid    = 1'b0;
      report_proc_id  = '0;
      report_chain    = '0;
      report_timeout  = 1'b0;
      unique case (state_q)
         IDLE: begin
         end
         ORIGIN: begin
            dl_detect_bcast = 1'b1;
            origin_vec      = win_oh;
         end
         WALK: begin
            dl_detect_bcast = 1'b1;
            if (ret)      token_clear_vec = win_oh;
            else if (tmo) token_clear_vec = '1;
         end
         REPORT: begin
            dl_detect_bcast = 1'b1;
            report_valid    = 1'b1;
            report_proc_id  = win;
            report_chain    = PROC_NUM'(rep_q.chain);
            report_timeout  = rep_q.timeout;
         end
      endcase
   end

endmodule
